// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a memory model. Read and write requests
// are granted round-robin into a single registered slot per path. Each
// accepted read records its owner in an in-order tag FIFO so that the
// in-order memory responses are routed back to the requester that issued them.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_DEPTH  = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  // requester read request channel
  input  logic [1:0]              REQ_READ_ADDR_VALID,
  input  logic [2*ADDR_WIDTH-1:0] REQ_READ_ADDR,
  input  logic [1:0]              REQ_READ_DATA_VALID,
  input  logic [2*DATA_WIDTH-1:0] REQ_READ_DATA,
  output logic [1:0]              REQ_READ_READY,
  // requester response channel (shared payload, per-requester valid)
  output logic [1:0]              REQ_RESP_VALID,
  output logic [ADDR_WIDTH-1:0]   REQ_RESP_ADDR,
  output logic                    REQ_RESP_DATA_VALID,
  output logic [DATA_WIDTH-1:0]   REQ_RESP_DATA,
  input  logic [1:0]              REQ_RESP_READY,
  // requester write channel
  input  logic [1:0]              REQ_WRITE_VALID,
  input  logic [2*ADDR_WIDTH-1:0] REQ_WRITE_DATA,
  output logic [1:0]              REQ_WRITE_READY,
  // memory read request channel
  output logic                    M_READ_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0]   M_READ_ADDR,
  output logic                    M_READ_DATA_VALID,
  output logic [DATA_WIDTH-1:0]   M_READ_DATA,
  input  logic                    M_READ_READY,
  // memory response channel
  input  logic                    M_RESP_VALID,
  input  logic [ADDR_WIDTH-1:0]   M_RESP_ADDR,
  input  logic                    M_RESP_DATA_VALID,
  input  logic [DATA_WIDTH-1:0]   M_RESP_DATA,
  output logic                    M_RESP_READY,
  // memory write channel
  output logic                    M_WRITE_VALID,
  output logic [ADDR_WIDTH-1:0]   M_WRITE_DATA,
  input  logic                    M_WRITE_READY
);

  localparam int PTR_W = $clog2(TAG_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);

  // read arbiter state
  logic rd_rr_q;        // requester favoured on a read tie
  logic rd_slot_free;
  logic rd_grant;
  logic rd_winner;

  // write arbiter state
  logic wr_rr_q;        // requester favoured on a write tie
  logic wr_slot_free;
  logic wr_grant;
  logic wr_winner;

  // tag FIFO
  logic             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] tag_wr_ptr;
  logic [PTR_W-1:0] tag_rd_ptr;
  logic [CNT_W-1:0] tag_count;
  logic             tag_head;
  logic             tag_nonempty;
  logic             tag_push;
  logic             tag_pop;

  // Read arbitration: pick the winner and grant when the slot can take it.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_winner      = 1'b0;
    REQ_READ_READY = 2'b00;
    rd_slot_free   = !M_READ_ADDR_VALID || M_READ_READY;
    if (REQ_READ_ADDR_VALID == 2'b11) begin
      rd_winner = rd_rr_q;
    end else if (REQ_READ_ADDR_VALID[1]) begin
      rd_winner = 1'b1;
    end
    // A full tag FIFO blocks the grant even if a response pops this cycle.
    rd_grant = !RST && (|REQ_READ_ADDR_VALID) && rd_slot_free && (tag_count != FULL_CNT);
    if (rd_grant) begin
      REQ_READ_READY[rd_winner] = 1'b1;
    end
  end

  // Read slot register: load on grant, otherwise empty once memory takes it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      M_READ_ADDR_VALID <= 1'b0;
      M_READ_ADDR       <= '0;
      M_READ_DATA_VALID <= 1'b0;
      M_READ_DATA       <= '0;
      rd_rr_q           <= 1'b0;
    end else if (rd_grant) begin
      M_READ_ADDR_VALID <= 1'b1;
      M_READ_ADDR       <= rd_winner ? REQ_READ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                     : REQ_READ_ADDR[ADDR_WIDTH-1:0];
      M_READ_DATA_VALID <= REQ_READ_DATA_VALID[rd_winner];
      M_READ_DATA       <= rd_winner ? REQ_READ_DATA[2*DATA_WIDTH-1:DATA_WIDTH]
                                     : REQ_READ_DATA[DATA_WIDTH-1:0];
      rd_rr_q           <= ~rd_winner;
    end else if (M_READ_READY) begin
      M_READ_ADDR_VALID <= 1'b0;
    end
  end

  // Write arbitration: same slot/round-robin scheme with its own pointer.
  always_comb begin
    wr_winner       = 1'b0;
    REQ_WRITE_READY = 2'b00;
    wr_slot_free    = !M_WRITE_VALID || M_WRITE_READY;
    if (REQ_WRITE_VALID == 2'b11) begin
      wr_winner = wr_rr_q;
    end else if (REQ_WRITE_VALID[1]) begin
      wr_winner = 1'b1;
    end
    wr_grant = !RST && (|REQ_WRITE_VALID) && wr_slot_free;
    if (wr_grant) begin
      REQ_WRITE_READY[wr_winner] = 1'b1;
    end
  end

  // Write slot register: load on grant, otherwise empty once memory takes it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      M_WRITE_VALID <= 1'b0;
      M_WRITE_DATA  <= '0;
      wr_rr_q       <= 1'b0;
    end else if (wr_grant) begin
      M_WRITE_VALID <= 1'b1;
      M_WRITE_DATA  <= wr_winner ? REQ_WRITE_DATA[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                 : REQ_WRITE_DATA[ADDR_WIDTH-1:0];
      wr_rr_q       <= ~wr_winner;
    end else if (M_WRITE_READY) begin
      M_WRITE_VALID <= 1'b0;
    end
  end

  // Response routing: the oldest tag selects which requester sees the response.
  always_comb begin
    tag_head       = tag_mem[tag_rd_ptr];
    tag_nonempty   = (tag_count != '0);
    REQ_RESP_VALID = 2'b00;
    M_RESP_READY   = !RST && tag_nonempty && REQ_RESP_READY[tag_head];
    if (!RST && M_RESP_VALID && tag_nonempty) begin
      REQ_RESP_VALID[tag_head] = 1'b1;
    end
    tag_push = rd_grant;
    tag_pop  = M_RESP_VALID && M_RESP_READY;
  end

  assign REQ_RESP_ADDR       = M_RESP_ADDR;
  assign REQ_RESP_DATA_VALID = M_RESP_DATA_VALID;
  assign REQ_RESP_DATA       = M_RESP_DATA;

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_count  <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_count <= tag_count + CNT_W'(1);
        2'b01:   tag_count <= tag_count - CNT_W'(1);
        default: tag_count <= tag_count;
      endcase
    end
  end

  // Tag storage: owner ID of each outstanding read.
  always_ff @(posedge CLK) begin
    // NOTE: storage is not reset; entries are only read while tag_count says they are valid.
    if (tag_push) tag_mem[tag_wr_ptr] <= rd_winner;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A memory model records accepted
// reads and replays them in order; expected response owners/data are queued
// by the bench when it drives requests and compared when responses appear.
module tb_mem_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TD = 4;

  logic            CLK = 1'b0;
  logic            RST;
  logic [1:0]      REQ_READ_ADDR_VALID;
  logic [2*AW-1:0] REQ_READ_ADDR;
  logic [1:0]      REQ_READ_DATA_VALID;
  logic [2*DW-1:0] REQ_READ_DATA;
  logic [1:0]      REQ_READ_READY;
  logic [1:0]      REQ_RESP_VALID;
  logic [AW-1:0]   REQ_RESP_ADDR;
  logic            REQ_RESP_DATA_VALID;
  logic [DW-1:0]   REQ_RESP_DATA;
  logic [1:0]      REQ_RESP_READY;
  logic [1:0]      REQ_WRITE_VALID;
  logic [2*AW-1:0] REQ_WRITE_DATA;
  logic [1:0]      REQ_WRITE_READY;
  logic            M_READ_ADDR_VALID;
  logic [AW-1:0]   M_READ_ADDR;
  logic            M_READ_DATA_VALID;
  logic [DW-1:0]   M_READ_DATA;
  logic            M_READ_READY;
  logic            M_RESP_VALID;
  logic [AW-1:0]   M_RESP_ADDR;
  logic            M_RESP_DATA_VALID;
  logic [DW-1:0]   M_RESP_DATA;
  logic            M_RESP_READY;
  logic            M_WRITE_VALID;
  logic [AW-1:0]   M_WRITE_DATA;
  logic            M_WRITE_READY;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_DEPTH(TD)) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .REQ_READ_ADDR_VALID (REQ_READ_ADDR_VALID),
    .REQ_READ_ADDR       (REQ_READ_ADDR),
    .REQ_READ_DATA_VALID (REQ_READ_DATA_VALID),
    .REQ_READ_DATA       (REQ_READ_DATA),
    .REQ_READ_READY      (REQ_READ_READY),
    .REQ_RESP_VALID      (REQ_RESP_VALID),
    .REQ_RESP_ADDR       (REQ_RESP_ADDR),
    .REQ_RESP_DATA_VALID (REQ_RESP_DATA_VALID),
    .REQ_RESP_DATA       (REQ_RESP_DATA),
    .REQ_RESP_READY      (REQ_RESP_READY),
    .REQ_WRITE_VALID     (REQ_WRITE_VALID),
    .REQ_WRITE_DATA      (REQ_WRITE_DATA),
    .REQ_WRITE_READY     (REQ_WRITE_READY),
    .M_READ_ADDR_VALID   (M_READ_ADDR_VALID),
    .M_READ_ADDR         (M_READ_ADDR),
    .M_READ_DATA_VALID   (M_READ_DATA_VALID),
    .M_READ_DATA         (M_READ_DATA),
    .M_READ_READY        (M_READ_READY),
    .M_RESP_VALID        (M_RESP_VALID),
    .M_RESP_ADDR         (M_RESP_ADDR),
    .M_RESP_DATA_VALID   (M_RESP_DATA_VALID),
    .M_RESP_DATA         (M_RESP_DATA),
    .M_RESP_READY        (M_RESP_READY),
    .M_WRITE_VALID       (M_WRITE_VALID),
    .M_WRITE_DATA        (M_WRITE_DATA),
    .M_WRITE_READY       (M_WRITE_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          owner;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t          exp_q[$];   // expected responses in issue order
  logic [AW-1:0] mem_q[$];   // addresses the memory model has accepted
  int            checks = 0;
  int            errors = 0;

  function automatic exp_t mk_exp(input logic owner, input logic [AW-1:0] addr);
    exp_t e;
    e.owner = owner;
    e.addr  = addr;
    return e;
  endfunction

  function automatic logic [1:0] onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

  // Memory model: capture reads at the negedge before the accepting edge.
  always @(negedge CLK) begin
    if (!RST && M_READ_ADDR_VALID && M_READ_READY) mem_q.push_back(M_READ_ADDR);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic reset_dut();
    RST                 = 1'b1;
    REQ_READ_ADDR_VALID = 2'b00;
    REQ_READ_ADDR       = '0;
    REQ_READ_DATA_VALID = 2'b00;
    REQ_READ_DATA       = '0;
    REQ_RESP_READY      = 2'b11;
    REQ_WRITE_VALID     = 2'b00;
    REQ_WRITE_DATA      = '0;
    M_READ_READY        = 1'b1;
    M_RESP_VALID        = 1'b0;
    M_RESP_ADDR         = '0;
    M_RESP_DATA_VALID   = 1'b0;
    M_RESP_DATA         = '0;
    M_WRITE_READY       = 1'b1;
    exp_q.delete();
    mem_q.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Present the oldest accepted read as a memory response and check routing.
  task automatic deliver_one(input string name);
    exp_t e;
    bit   ok;
    if (mem_q.size() == 0 || exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_queue: got mem=%0d exp=%0d entries, want both nonzero", name, mem_q.size(), exp_q.size());
      return;
    end
    M_RESP_VALID      = 1'b1;
    M_RESP_ADDR       = mem_q[0];
    M_RESP_DATA_VALID = 1'b1;
    M_RESP_DATA       = mem_q[0] + 32'h9B;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (M_RESP_READY === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout: got M_RESP_READY=0 for 20 cycles, want 1", name);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (REQ_RESP_VALID !== onehot(e.owner)) begin
        errors++;
        $display("FAIL %s_route: got %b want %b", name, REQ_RESP_VALID, onehot(e.owner));
      end
      checks++;
      if (REQ_RESP_DATA !== e.addr + 32'h9B) begin
        errors++;
        $display("FAIL %s_data: got %h want %h", name, REQ_RESP_DATA, e.addr + 32'h9B);
      end
      checks++;
      if (REQ_RESP_ADDR !== e.addr) begin
        errors++;
        $display("FAIL %s_addr: got %h want %h", name, REQ_RESP_ADDR, e.addr);
      end
    end
    @(posedge CLK);
    #1;
    void'(mem_q.pop_front());
    M_RESP_VALID = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    RST                 = 1'b1;
    REQ_READ_ADDR_VALID = 2'b11;
    REQ_WRITE_VALID     = 2'b11;
    M_RESP_VALID        = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b00) begin errors++; $display("FAIL reset_read_ready: got %b want 00", REQ_READ_READY); end
    checks++;
    if (REQ_WRITE_READY !== 2'b00) begin errors++; $display("FAIL reset_write_ready: got %b want 00", REQ_WRITE_READY); end
    checks++;
    if (REQ_RESP_VALID !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", REQ_RESP_VALID); end
    checks++;
    if (M_RESP_READY !== 1'b0) begin errors++; $display("FAIL reset_m_resp_ready: got %b want 0", M_RESP_READY); end
    checks++;
    if (M_READ_ADDR_VALID !== 1'b0 || M_READ_ADDR !== '0) begin
      errors++; $display("FAIL reset_m_read: got v=%b a=%h want 0/0", M_READ_ADDR_VALID, M_READ_ADDR);
    end
    checks++;
    if (M_WRITE_VALID !== 1'b0 || M_WRITE_DATA !== '0) begin
      errors++; $display("FAIL reset_m_write: got v=%b d=%h want 0/0", M_WRITE_VALID, M_WRITE_DATA);
    end
  endtask

  task automatic test_solo_read();
    reset_dut();
    REQ_READ_ADDR_VALID = 2'b01;
    REQ_READ_ADDR       = {32'h0, 32'h10};
    REQ_READ_DATA_VALID = 2'b01;
    REQ_READ_DATA       = {32'h0, 32'h77};
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b01) begin errors++; $display("FAIL solo_grant: got %b want 01", REQ_READ_READY); end
    exp_q.push_back(mk_exp(1'b0, 32'h10));
    tick();
    REQ_READ_ADDR_VALID = 2'b00;
    @(negedge CLK);
    checks++;
    if (M_READ_ADDR_VALID !== 1'b1 || M_READ_ADDR !== 32'h10) begin
      errors++; $display("FAIL solo_m_read: got v=%b a=%h want 1/10", M_READ_ADDR_VALID, M_READ_ADDR);
    end
    checks++;
    if (M_READ_DATA_VALID !== 1'b1 || M_READ_DATA !== 32'h77) begin
      errors++; $display("FAIL solo_m_data: got v=%b d=%h want 1/77", M_READ_DATA_VALID, M_READ_DATA);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (M_READ_ADDR_VALID !== 1'b0) begin errors++; $display("FAIL solo_slot_drain: got %b want 0", M_READ_ADDR_VALID); end
    tick();
    deliver_one("solo_resp");
    // A response with nothing outstanding must stall untouched.
    M_RESP_VALID = 1'b1;
    M_RESP_ADDR  = 32'hDEAD;
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (M_RESP_READY !== 1'b0 || REQ_RESP_VALID !== 2'b00) begin
        errors++; $display("FAIL empty_resp: got ready=%b valid=%b want 0/00", M_RESP_READY, REQ_RESP_VALID);
      end
      tick();
    end
    M_RESP_VALID = 1'b0;
  endtask

  task automatic test_contention();
    logic [AW-1:0] a0, a1, last;
    logic          exp_w;
    reset_dut();
    a0 = 32'h100;
    a1 = 32'h200;
    exp_w = 1'b0;
    last = '0;
    REQ_READ_ADDR_VALID = 2'b11;
    REQ_READ_ADDR       = {a1, a0};
    for (int k = 0; k < TD; k++) begin
      @(negedge CLK);
      if (k > 0) begin
        checks++;
        if (M_READ_ADDR !== last) begin errors++; $display("FAIL cont_m_addr%0d: got %h want %h", k, M_READ_ADDR, last); end
      end
      checks++;
      if (REQ_READ_READY !== onehot(exp_w)) begin
        errors++; $display("FAIL cont_grant%0d: got %b want %b", k, REQ_READ_READY, onehot(exp_w));
      end
      last = exp_w ? a1 : a0;
      exp_q.push_back(mk_exp(exp_w, last));
      tick();
      if (exp_w) a1 = a1 + 32'h4; else a0 = a0 + 32'h4;
      REQ_READ_ADDR = {a1, a0};
      exp_w = ~exp_w;
    end
    @(negedge CLK);
    checks++;
    if (M_READ_ADDR !== last) begin errors++; $display("FAIL cont_m_addr_last: got %h want %h", M_READ_ADDR, last); end
    checks++;
    if (REQ_READ_READY !== 2'b00) begin errors++; $display("FAIL cont_full: got %b want 00", REQ_READ_READY); end
    tick();
    REQ_READ_ADDR_VALID = 2'b00;
    for (int k = 0; k < TD; k++) deliver_one("cont_resp");
  endtask

  task automatic test_tag_full();
    logic [AW-1:0] a;
    reset_dut();
    a = 32'h300;
    REQ_READ_ADDR_VALID = 2'b01;
    REQ_READ_ADDR       = {32'h0, a};
    for (int k = 0; k < TD; k++) begin
      @(negedge CLK);
      checks++;
      if (REQ_READ_READY !== 2'b01) begin errors++; $display("FAIL full_fill%0d: got %b want 01", k, REQ_READ_READY); end
      exp_q.push_back(mk_exp(1'b0, a));
      tick();
      a = a + 32'h4;
      REQ_READ_ADDR = {32'h0, a};
    end
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (REQ_READ_READY !== 2'b00) begin errors++; $display("FAIL full_block: got %b want 00", REQ_READ_READY); end
      tick();
    end
    // Pop one response; no grant may happen in the pop cycle itself.
    M_RESP_VALID      = 1'b1;
    M_RESP_ADDR       = mem_q[0];
    M_RESP_DATA_VALID = 1'b1;
    M_RESP_DATA       = mem_q[0] + 32'h9B;
    @(negedge CLK);
    checks++;
    if (M_RESP_READY !== 1'b1 || REQ_READ_READY !== 2'b00) begin
      errors++; $display("FAIL full_pop_cycle: got resp_ready=%b read_ready=%b want 1/00", M_RESP_READY, REQ_READ_READY);
    end
    checks++;
    if (REQ_RESP_DATA !== exp_q[0].addr + 32'h9B) begin
      errors++; $display("FAIL full_pop_data: got %h want %h", REQ_RESP_DATA, exp_q[0].addr + 32'h9B);
    end
    tick();
    void'(mem_q.pop_front());
    void'(exp_q.pop_front());
    M_RESP_VALID = 1'b0;
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b01) begin errors++; $display("FAIL full_regrant: got %b want 01", REQ_READ_READY); end
    exp_q.push_back(mk_exp(1'b0, a));
    tick();
    a = a + 32'h4;
    REQ_READ_ADDR = {32'h0, a};
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b00) begin errors++; $display("FAIL full_one_only: got %b want 00", REQ_READ_READY); end
    tick();
    REQ_READ_ADDR_VALID = 2'b00;
    for (int k = 0; k < TD; k++) deliver_one("full_resp");
  endtask

  task automatic test_write_backpressure();
    reset_dut();
    M_WRITE_READY   = 1'b0;
    REQ_WRITE_VALID = 2'b10;
    REQ_WRITE_DATA  = {32'h55, 32'h0};
    @(negedge CLK);
    checks++;
    if (REQ_WRITE_READY !== 2'b10) begin errors++; $display("FAIL wr_grant: got %b want 10", REQ_WRITE_READY); end
    tick();
    REQ_WRITE_DATA = {32'h66, 32'h0};
    repeat (2) begin
      @(negedge CLK);
      checks++;
      if (M_WRITE_VALID !== 1'b1 || M_WRITE_DATA !== 32'h55 || REQ_WRITE_READY !== 2'b00) begin
        errors++; $display("FAIL wr_hold: got v=%b d=%h rdy=%b want 1/55/00", M_WRITE_VALID, M_WRITE_DATA, REQ_WRITE_READY);
      end
      tick();
    end
    M_WRITE_READY = 1'b1;
    @(negedge CLK);
    checks++;
    if (REQ_WRITE_READY !== 2'b10) begin errors++; $display("FAIL wr_refill: got %b want 10", REQ_WRITE_READY); end
    tick();
    REQ_WRITE_VALID = 2'b00;
    @(negedge CLK);
    checks++;
    if (M_WRITE_VALID !== 1'b1 || M_WRITE_DATA !== 32'h66) begin
      errors++; $display("FAIL wr_second: got v=%b d=%h want 1/66", M_WRITE_VALID, M_WRITE_DATA);
    end
    tick();
    @(negedge CLK);
    checks++;
    if (M_WRITE_VALID !== 1'b0) begin errors++; $display("FAIL wr_drain: got %b want 0", M_WRITE_VALID); end
    tick();
    // Read and write grant in the same cycle; write pointer now favours 0.
    REQ_WRITE_VALID     = 2'b11;
    REQ_WRITE_DATA      = {32'hB1, 32'hA0};
    REQ_READ_ADDR_VALID = 2'b10;
    REQ_READ_ADDR       = {32'h600, 32'h0};
    @(negedge CLK);
    checks++;
    if (REQ_WRITE_READY !== 2'b01 || REQ_READ_READY !== 2'b10) begin
      errors++; $display("FAIL both_paths: got wr=%b rd=%b want 01/10", REQ_WRITE_READY, REQ_READ_READY);
    end
    exp_q.push_back(mk_exp(1'b1, 32'h600));
    tick();
    REQ_WRITE_VALID     = 2'b10;
    REQ_READ_ADDR_VALID = 2'b00;
    @(negedge CLK);
    checks++;
    if (M_WRITE_DATA !== 32'hA0 || REQ_WRITE_READY !== 2'b10) begin
      errors++; $display("FAIL wr_rr: got d=%h rdy=%b want A0/10", M_WRITE_DATA, REQ_WRITE_READY);
    end
    tick();
    REQ_WRITE_VALID = 2'b00;
    @(negedge CLK);
    checks++;
    if (M_WRITE_DATA !== 32'hB1) begin errors++; $display("FAIL wr_rr_second: got %h want B1", M_WRITE_DATA); end
    tick();
    deliver_one("both_resp");
  endtask

  task automatic test_head_stall();
    reset_dut();
    REQ_RESP_READY      = 2'b01;
    REQ_READ_ADDR_VALID = 2'b10;
    REQ_READ_ADDR       = {32'h400, 32'h0};
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b10) begin errors++; $display("FAIL stall_grant1: got %b want 10", REQ_READ_READY); end
    exp_q.push_back(mk_exp(1'b1, 32'h400));
    tick();
    REQ_READ_ADDR_VALID = 2'b01;
    REQ_READ_ADDR       = {32'h0, 32'h500};
    @(negedge CLK);
    checks++;
    if (REQ_READ_READY !== 2'b01) begin errors++; $display("FAIL stall_grant0: got %b want 01", REQ_READ_READY); end
    exp_q.push_back(mk_exp(1'b0, 32'h500));
    tick();
    REQ_READ_ADDR_VALID = 2'b00;
    tick();
    M_RESP_VALID      = 1'b1;
    M_RESP_ADDR       = mem_q[0];
    M_RESP_DATA_VALID = 1'b1;
    M_RESP_DATA       = mem_q[0] + 32'h9B;
    repeat (3) begin
      @(negedge CLK);
      checks++;
      if (M_RESP_READY !== 1'b0 || REQ_RESP_VALID !== 2'b10) begin
        errors++; $display("FAIL stall_hold: got ready=%b valid=%b want 0/10", M_RESP_READY, REQ_RESP_VALID);
      end
      tick();
    end
    M_RESP_VALID   = 1'b0;
    REQ_RESP_READY = 2'b11;
    deliver_one("stall_resp1");
    deliver_one("stall_resp0");
  endtask

  task automatic test_async_reset();
    reset_dut();
    REQ_READ_ADDR_VALID = 2'b11;
    REQ_READ_ADDR       = {32'h800, 32'h700};
    REQ_WRITE_VALID     = 2'b01;
    tick();
    tick();
    #3;
    RST = 1'b1;
    #1;
    checks++;
    if (M_READ_ADDR_VALID !== 1'b0 || M_WRITE_VALID !== 1'b0 || REQ_READ_READY !== 2'b00) begin
      errors++; $display("FAIL async_clear: got rv=%b wv=%b rdy=%b want 0/0/00", M_READ_ADDR_VALID, M_WRITE_VALID, REQ_READ_READY);
    end
    exp_q.delete();
    mem_q.delete();
    REQ_WRITE_VALID = 2'b00;
    @(posedge CLK);
    #2;
    RST = 1'b0;
    M_RESP_VALID = 1'b1;
    M_RESP_ADDR  = 32'h700;
    @(negedge CLK);
    checks++;
    if (M_RESP_READY !== 1'b0 || REQ_RESP_VALID !== 2'b00) begin
      errors++; $display("FAIL async_tags_gone: got ready=%b valid=%b want 0/00", M_RESP_READY, REQ_RESP_VALID);
    end
    checks++;
    if (REQ_READ_READY !== 2'b01) begin errors++; $display("FAIL async_first_grant: got %b want 01", REQ_READ_READY); end
    tick();
    REQ_READ_ADDR_VALID = 2'b00;
    M_RESP_VALID        = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_solo_read();
    test_contention();
    test_tag_full();
    test_write_backpressure();
    test_head_stall();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares one memory read-request/response channel pair and one write channel between two dataflow units (e.g., two processing-element clusters) in front of the memory model. Read and write requests are granted round-robin and registered onto the memory side. Each accepted read records its owner in an in-order tag FIFO, so responses, which the memory returns in request order, are routed back to the requester that issued them.

## Interface
Parameters:
- DATA_WIDTH, 32, data payload width
- ADDR_WIDTH, 32, address width
- TAG_DEPTH, 4, maximum outstanding reads (power of 2, ≥2)

Ports (vectors: requester i occupies slice [i] or [i*W +: W]):
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-high
- REQ_READ_ADDR_VALID  in  2  per-requester read request valid
- REQ_READ_ADDR  in  2*ADDR_WIDTH  read addresses
- REQ_READ_DATA_VALID  in  2  per-request data-present flag, carried with the request
- REQ_READ_DATA  in  2*DATA_WIDTH  per-request data, carried with the request
- REQ_READ_READY  out  2  read request grant/accept
- REQ_RESP_VALID  out  2  response valid to requester
- REQ_RESP_ADDR  out  ADDR_WIDTH  response address (shared bus)
- REQ_RESP_DATA_VALID  out  1  response data-present flag (shared)
- REQ_RESP_DATA  out  DATA_WIDTH  response data (shared)
- REQ_RESP_READY  in  2  requester response ready
- REQ_WRITE_VALID  in  2  write valid
- REQ_WRITE_DATA  in  2*ADDR_WIDTH  write payload
- REQ_WRITE_READY  out  2  write accept
- M_READ_ADDR_VALID, M_READ_ADDR, M_READ_DATA_VALID, M_READ_DATA  out  1/ADDR_WIDTH/1/DATA_WIDTH  registered read request to memory
- M_READ_READY  in  1  memory accepts read request
- M_RESP_VALID, M_RESP_ADDR, M_RESP_DATA_VALID, M_RESP_DATA  in  1/ADDR_WIDTH/1/DATA_WIDTH  in-order memory response
- M_RESP_READY  out  1  response accept
- M_WRITE_VALID, M_WRITE_DATA  out  1/ADDR_WIDTH  registered write to memory
- M_WRITE_READY  in  1  memory accepts write

## Operation
- A handshake occurs when VALID and READY are both high on a rising CLK edge. Once asserted, VALID and payload stay stable until the handshake completes.
- Read arbiter:
  - Slot free = M_READ_ADDR_VALID==0, or M_READ_READY==1 this cycle.
  - The arbiter grants only if the slot is free and tag count < TAG_DEPTH.
  - Winner: the single requester with valid; if both are valid, the one not granted last (RR pointer).
  - REQ_READ_READY is asserted only for the winner and is combinational from the current valids and state.
  - On grant: the request fields load into the M_READ_* register, the winner ID is pushed into the tag FIFO, and the RR pointer moves to favor the other requester.
- Response router:
  - Head = oldest tag.
  - REQ_RESP_VALID[head] = M_RESP_VALID & (count≠0); the other bit is 0.
  - The shared REQ_RESP_* buses carry M_RESP_* unchanged.
  - M_RESP_READY = (count≠0) & REQ_RESP_READY[head].
  - The FIFO pops on M_RESP handshake.
- Write arbiter: same slot/RR scheme with an independent pointer and no tag. A granted payload loads into M_WRITE_DATA.
- Read and write paths are fully independent. Both may grant in the same cycle.

## Timing
- Reset values:
  - M_READ_ADDR_VALID=0, M_WRITE_VALID=0, M_READ_* and M_WRITE_DATA = 0.
  - Both RR pointers favor requester 0.
  - Tag FIFO empty (count=0, pointers 0).
  - All READY/RESP_VALID outputs are 0 while RST is high.
- Latency:
  - Request grant at edge N drives M_*_VALID high after edge N.
  - Response routing has zero latency (combinational).
- Throughput: one grant per cycle per path when memory holds READY high. The slot refills in the same cycle it drains.
- Tag FIFO full (count==TAG_DEPTH): no read grant, even if a pop occurs the same cycle. A same-cycle push+pop below full leaves count unchanged.
- Response with count==0: M_RESP_READY=0 and no REQ_RESP_VALID. The response stalls indefinitely; no state changes.
- Head requester not ready: the response stalls. The other requester's responses queue behind it (in-order, no bypass).
- Tag pointers wrap modulo TAG_DEPTH. Count is log2(TAG_DEPTH)+1 bits.
- Reset mid-operation: all registers clear immediately (asynchronous), and outstanding tags are discarded. Memory must be reset concurrently.

## Test plan
- Solo read: req0 valid, addr 0x10, M_READ_READY=1 → READY[0] at edge 0; M_READ_ADDR_VALID=1, addr 0x10 next cycle. Response 0xAB → REQ_RESP_VALID=2'b01, DATA=0xAB, FIFO pops.
- Contention: both requesters hold read valid for 4 cycles, memory always ready → grants 0,1,0,1. M_READ_ADDR alternates. Responses route to 01,10,01,10.
- Tag full: TAG_DEPTH=4, memory ready, no responses → 4 grants, then READY=0. One response pop → exactly one further grant on the following cycle.
- Backpressure: M_WRITE_READY=0 with req1 writing 0x55 → M_WRITE_VALID held with 0x55 and no further write grants. READY high → drains, and the next grant happens in the same cycle.
- Head stall: tags [1,0], REQ_RESP_READY=2'b01 → M_RESP_READY=0 until bit1 rises. Then both responses deliver in order.
- Async reset: assert RST mid-burst between edges → all valids 0 and count 0 immediately. After release, the first grant goes to requester 0.
